// File: rtl/gtxe2_chnl_tx_oob_defs.sv
// Shared OOB timing definitions for the GTXE2 TX/RX OOB channel blocks:
// FSM state encoding, default burst/gap lengths and the counter-width helper.
package gtxe2_chnl_tx_oob_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } oob_state_e;

  localparam int unsigned DEF_BURST_LEN     = 160;
  localparam int unsigned DEF_INIT_IDLE_LEN = 480;
  localparam int unsigned DEF_WAKE_IDLE_LEN = 160;
  localparam int unsigned DEF_SAS_IDLE_LEN  = 1440;
  localparam int unsigned DEF_BURST_CNT     = 6;

  // Burst count is 1..15, so four bits always suffice.
  localparam int unsigned BURST_CNT_W = 4;

  function automatic int unsigned oob_cnt_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c,
                                                input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_cnt.sv
// Loadable down-counter with a terminal flag; holds at zero once reached.
module gtxe2_chnl_tx_oob_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_term = (r_cnt == '0);

endmodule

// File: rtl/gtxe2_chnl_tx_oob.sv
// GTXE2 TX OOB sequencer: COMINIT/COMWAKE (and COMSAS when built with
// GTXE2_TX_OOB_COMSAS_EN) burst+gap sequences on a registered TXP/TXN pair.
module gtxe2_chnl_tx_oob
  import gtxe2_chnl_tx_oob_defs::*;
#(
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned INIT_IDLE_LEN = DEF_INIT_IDLE_LEN,
  parameter int unsigned WAKE_IDLE_LEN = DEF_WAKE_IDLE_LEN,
  parameter int unsigned SAS_IDLE_LEN  = DEF_SAS_IDLE_LEN,
  parameter int unsigned BURST_CNT     = DEF_BURST_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic txd_ser,
  input  logic TXELECIDLE,
  input  logic TXCOMINIT,
  input  logic TXCOMWAKE,
  input  logic TXCOMSAS,
  output logic TXP,
  output logic TXN,
  output logic TXCOMFINISH
);

  logic w_sas_req;

`ifdef GTXE2_TX_OOB_COMSAS_EN
  localparam int unsigned SAS_LEN_FOR_W = SAS_IDLE_LEN;
  assign w_sas_req = TXCOMSAS;
`else
  localparam int unsigned SAS_LEN_FOR_W = 0;
  localparam int unsigned SAS_LEN_UNUSED = SAS_IDLE_LEN;
  logic w_unused_sas;
  assign w_unused_sas = TXCOMSAS;
  assign w_sas_req    = 1'b0;
`endif

  localparam int unsigned CNT_W =
    oob_cnt_width(BURST_LEN, INIT_IDLE_LEN, WAKE_IDLE_LEN, SAS_LEN_FOR_W);

  // Counter values are stored as length-1 so the terminal flag marks the last cycle.
  localparam logic [CNT_W-1:0] LP_BURST_LD = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LP_INIT_LD  = CNT_W'(INIT_IDLE_LEN - 1);
  localparam logic [CNT_W-1:0] LP_WAKE_LD  = CNT_W'(WAKE_IDLE_LEN - 1);
`ifdef GTXE2_TX_OOB_COMSAS_EN
  localparam logic [CNT_W-1:0] LP_SAS_LD   = CNT_W'(SAS_IDLE_LEN - 1);
`endif
  localparam logic [BURST_CNT_W-1:0] LP_BURST_CNT = BURST_CNT_W'(BURST_CNT);

  oob_state_e              r_state, w_state_nx;
  logic [CNT_W-1:0]        r_gap, w_gap_nx;
  logic [BURST_CNT_W-1:0]  r_burst, w_burst_nx, w_burst_inc;
  logic                    r_tog, w_tog_nx;
  logic                    r_txp, r_txn, r_fin;
  logic                    w_txp_nx, w_txn_nx;
  logic                    w_load;
  logic [CNT_W-1:0]        w_load_val;
  logic                    w_term;

  gtxe2_chnl_tx_oob_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_term     (w_term)
  );

  assign w_burst_inc = r_burst + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap;
    w_burst_nx = r_burst;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (TXCOMINIT || TXCOMWAKE || w_sas_req) begin
          w_state_nx = ST_BURST;
          w_burst_nx = '0;
          w_load     = 1'b1;
          w_load_val = LP_BURST_LD;
          if (TXCOMINIT)      w_gap_nx = LP_INIT_LD;
          else if (TXCOMWAKE) w_gap_nx = LP_WAKE_LD;
`ifdef GTXE2_TX_OOB_COMSAS_EN
          else                w_gap_nx = LP_SAS_LD;
`endif
        end
      end
      ST_BURST: begin
        if (w_term) begin
          w_state_nx = ST_GAP;
          w_load     = 1'b1;
          w_load_val = r_gap;
        end
      end
      ST_GAP: begin
        if (w_term) begin
          w_burst_nx = w_burst_inc;
          if (w_burst_inc < LP_BURST_CNT) begin
            w_state_nx = ST_BURST;
            w_load     = 1'b1;
            w_load_val = LP_BURST_LD;
          end else begin
            w_state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Burst phase restarts at 0 outside BURST so each burst begins with TXP = 1.
  always_comb begin
    w_tog_nx = 1'b0;
    w_txp_nx = 1'b0;
    w_txn_nx = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!TXELECIDLE) begin
          w_txp_nx = txd_ser;
          w_txn_nx = ~txd_ser;
        end
      end
      ST_BURST: begin
        w_tog_nx = ~r_tog;
        w_txp_nx = ~r_tog;
        w_txn_nx = r_tog;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_burst <= '0;
      r_tog   <= 1'b0;
      r_txp   <= 1'b0;
      r_txn   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gap   <= w_gap_nx;
      r_burst <= w_burst_nx;
      r_tog   <= w_tog_nx;
      r_txp   <= w_txp_nx;
      r_txn   <= w_txn_nx;
      r_fin   <= (r_state == ST_DONE);
    end
  end

  assign TXP         = r_txp;
  assign TXN         = r_txn;
  assign TXCOMFINISH = r_fin;

endmodule
